fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_pkg.sv | 25 ++
 rtl/skid_buf2.sv | 49 ++++
 rtl/fifo_rd_stream.sv | 65 ++++++
 tb/tb_fifo_rd_stream.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
// No ports: this package holds the output-buffer depth, the occupancy and
// in-flight counter widths, and the credit check used to gate FIFO reads.
package fifo_rd_pkg;

    localparam int BUF_DEPTH = 2;   // words held in the output skid buffer
    localparam int CNT_W     = 2;   // buffer occupancy 0..BUF_DEPTH
    localparam int INFL_W    = 1;   // at most one pop outstanding
    localparam int PTR_W     = 1;   // index into the 2-entry buffer

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [INFL_W-1:0] infl_t;
    typedef logic [CNT_W:0]    occ_t;

    localparam occ_t DEPTH_OCC = occ_t'(BUF_DEPTH);

    // A new pop is allowed only if buffered + in-flight words, minus the word
    // leaving this cycle, still leave a free slot for the pop's data.
    function automatic logic has_credit(cnt_t cnt, infl_t inflight, logic drain);
        occ_t occ;
        occ = occ_t'(cnt) + occ_t'(inflight) - occ_t'(drain);
        return (occ < DEPTH_OCC);
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry output buffer: storage, read/write pointers and occupancy count.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (control only)
//   flush         - empties the buffer; overrides write and read
//   wr_en/wr_data - push one word at the tail
//   rd_en         - pop the head word
//   rd_data       - head word (oldest buffered)
//   cnt           - number of buffered words, 0..2
module skid_buf2
    import fifo_rd_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output cnt_t          cnt
);

    logic [DW-1:0]    mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            // A simultaneous write and read leaves cnt unchanged.
            cnt <= cnt + cnt_t'(wr_en) - cnt_t'(rd_en);
        end
    end

    // Storage is not reset; stale contents are never visible because cnt
    // gates validity.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a FIFO read port (1-cycle read latency) into a valid/ready stream.
// Ports:
//   clk, rst      - FIFO read clock, synchronous active-high reset
//   rempty        - FIFO empty flag
//   rinc          - FIFO read enable (combinational, credit gated)
//   rdata         - FIFO read data, valid the cycle after a pop
//   flush         - discards buffered and in-flight words
//   m_valid/m_ready/m_data - stream output, m_data is the oldest word
//   word_cnt      - count of delivered words, wraps modulo 2^CW
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rempty,
    output logic          rinc,
    input  logic [DW-1:0] rdata,
    input  logic          flush,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [CW-1:0] word_cnt
);

    cnt_t  cnt;
    infl_t vld_p1;   // a pop was accepted last cycle; rdata is live now
    logic  pop;
    logic  drain;
    logic  wr_en;

    // m_valid comes from registered occupancy only, never from rdata.
    assign m_valid = (cnt != '0) && !rst;
    assign drain   = m_valid && m_ready && !flush;
    assign rinc    = !rst && !rempty && !flush && has_credit(cnt, vld_p1, drain);
    assign pop     = rinc && !rempty;
    // A flush drops the word returning from an earlier pop.
    assign wr_en   = (vld_p1 != '0) && !flush && !rst;

    // ---- stage p0 -> p1: pop accepted, FIFO data returns next cycle ----
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= '0;
        else     vld_p1 <= infl_t'(pop);
    end

    // ---- stage p1 -> buffer: returning word captured at the tail ----
    skid_buf2 #(.DW(DW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (rdata),
        .rd_en   (drain),
        .rd_data (m_data),
        .cnt     (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst)        word_cnt <= '0;
        else if (drain) word_cnt <= word_cnt + CW'(1);
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rempty;
    logic          rinc;
    logic [DW-1:0] rdata;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] word_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int out_count = 0;
    logic [DW-1:0] last_out = '0;
    logic [CW-1:0] exp_cnt = '0;
    logic pop_n = 1'b0;

    logic [DW-1:0] fq[$];     // contents of the FIFO feeding the DUT
    logic [DW-1:0] exp_q[$];  // words popped and owed to the stream, oldest first
    int dcyc[$];              // cycle of each delivery

    always #5 clk = ~clk;

    assign rempty = (fq.size() == 0);

    fifo_rd_stream #(.DW(DW), .CW(CW)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .rempty   (rempty),
        .rinc     (rinc),
        .rdata    (rdata),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .word_cnt (word_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: a pop seen at the edge returns its word one cycle later.
    always @(negedge clk) pop_n <= rinc && !rempty;

    always @(posedge clk) begin
        if (pop_n && fq.size() > 0) rdata <= fq[0];
        #1;
        if (pop_n && fq.size() > 0) begin
            exp_q.push_back(fq.pop_front());
            pops <= pops + 1;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_m_valid", m_valid, 0);
            chk("rst_rinc", rinc, 0);
            exp_q.delete();
            exp_cnt <= '0;
        end else begin
            chk("word_cnt", word_cnt, exp_cnt);
            chk("rinc_when_empty", rinc && rempty, 0);
            chk("rinc_when_flush", rinc && flush, 0);
            chk("credit", rinc && ((exp_q.size() - ((m_valid && m_ready && !flush) ? 1 : 0)) >= 2), 0);
            if (flush) begin
                exp_q.delete();
            end else if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("phantom_word", m_valid, 0);
                end else begin
                    chk("m_data", m_data, exp_q[0]);
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        exp_cnt   <= exp_cnt + 1'b1;
                        out_count <= out_count + 1;
                        last_out  <= m_data;
                        dcyc.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int n, input int budget, input string nm);
        int k = 0;
        while (out_count < n && k < budget) begin
            step(1);
            k++;
        end
        if (out_count < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout delivered=%0d required=%0d", nm, out_count, n);
        end
    endtask

    task automatic wait_rinc(output int t, input string nm);
        t = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rinc) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL %s no rinc actual=0 required=1", nm);
        end
        step(1);
    endtask

    initial begin
        int t0;
        int n0;
        int sent;
        int k;

        // Streaming 1..8 at full rate; preload while reset holds rinc low.
        rst = 1'b1; flush = 1'b0; m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));
        step(2);
        dcyc.delete();
        rst = 1'b0;
        wait_rinc(t0, "t1_first_rinc");
        wait_out(8, 50, "t1_deliver");
        for (int i = 0; i < 8 && i < dcyc.size(); i++)
            chk("t1_delivery_cycle", dcyc[i], t0 + 2 + i);
        chk("t1_last_word", last_out, 16'h0008);
        chk("t1_word_cnt", word_cnt, 8);

        // Back-pressure: only two pops while the sink stalls, head held.
        rst = 1'b1; m_ready = 1'b0;
        fq.delete();
        for (int i = 0; i < 4; i++) fq.push_back(DW'(16'h21 + i));
        step(2);
        rst = 1'b0;
        n0 = pops;
        step(10);
        chk("t2_pops", pops - n0, 2);
        chk("t2_buffered", exp_q.size(), 2);
        chk("t2_m_valid", m_valid, 1);
        chk("t2_head", m_data, 16'h21);
        step(3);
        chk("t2_head_stable", m_data, 16'h21);
        m_ready = 1'b1;
        n0 = out_count;
        wait_out(n0 + 4, 40, "t2_deliver");
        chk("t2_last_word", last_out, 16'h24);
        chk("t2_fifo_drained", fq.size(), 0);

        // Flush with one word buffered and one in flight.
        rst = 1'b1; m_ready = 1'b0;
        fq.delete();
        for (int i = 0; i < 4; i++) fq.push_back(DW'(16'h31 + i));
        step(2);
        rst = 1'b0;
        wait_rinc(t0, "t3_first_rinc");
        step(1);
        chk("t3_pre_flush_valid", m_valid, 1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("t3_post_flush_valid", m_valid, 0);
        m_ready = 1'b1;
        n0 = out_count;
        wait_out(n0 + 1, 20, "t3_deliver");
        chk("t3_next_word", last_out, 16'h33);
        wait_out(n0 + 2, 20, "t3_deliver2");
        chk("t3_last_word", last_out, 16'h34);

        // word_cnt wrap at 2^CW.
        rst = 1'b1; m_ready = 1'b1;
        fq.delete();
        for (int i = 0; i < 15; i++) fq.push_back(DW'(16'h40 + i));
        step(2);
        rst = 1'b0;
        n0 = out_count;
        wait_out(n0 + 15, 60, "t4_deliver");
        step(1);
        chk("t4_word_cnt_max", word_cnt, 15);
        fq.push_back(16'h4F);
        wait_out(n0 + 16, 20, "t4_deliver_wrap");
        step(1);
        chk("t4_word_cnt_wrap", word_cnt, 0);

        // Reset with a full buffer and nothing in flight.
        rst = 1'b1; m_ready = 1'b1;
        fq.delete();
        for (int i = 0; i < 6; i++) fq.push_back(DW'(16'h50 + i));
        step(2);
        rst = 1'b0;
        step(4);
        m_ready = 1'b0;
        step(10);
        chk("t5_setup_buffered", exp_q.size(), 2);
        chk("t5_setup_word_cnt_nonzero", word_cnt != 0, 1);
        fq.delete();
        rst = 1'b1;
        step(1);
        chk("t5_rst_valid", m_valid, 0);
        rst = 1'b0;
        step(1);
        chk("t5_word_cnt", word_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t5_no_phantom", m_valid, 0);
            step(1);
        end

        // Reset with one pop in flight and an empty buffer.
        rst = 1'b1;
        fq.push_back(16'h5A);
        step(2);
        rst = 1'b0;
        wait_rinc(t0, "t5b_first_rinc");
        chk("t5b_inflight", exp_q.size(), 1);
        chk("t5b_valid_before", m_valid, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        m_ready = 1'b1;
        step(1);
        chk("t5b_word_cnt", word_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t5b_no_phantom", m_valid, 0);
            step(1);
        end

        // Random traffic: 1000 words, 50% sink readiness.
        rst = 1'b1;
        fq.delete();
        step(2);
        rst = 1'b0;
        n0 = out_count;
        sent = 0;
        k = 0;
        while (out_count < n0 + 1000 && k < 20000) begin
            if (sent < 1000 && $urandom_range(0, 99) < 70) begin
                fq.push_back(DW'($urandom));
                sent++;
            end
            m_ready = ($urandom_range(0, 1) == 1);
            step(1);
            k++;
        end
        chk("t6_delivered", out_count - n0, 1000);
        chk("t6_scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
